spi_ram_target: RTL and testbench

SPI mode-0 target that emulates the external instruction/data RAM the CPU's SPI reader talks to. It decodes READ (0x03) and WRITE (0x02) commands with a 16-bit address and serves them from an internal byte memory. It also has a local load port so a bench or host can preload programs. It sits on the far end of the CPU's `spi_cs_n/spi_sck/spi_mosi/spi_miso` wires, as a synthesizable stand-in for the RP2040 emulator.

---
 rtl/spi_ram_target_pkg.sv | 25 ++
 rtl/spi_pin_sync.sv | 42 ++++
 rtl/spi_ram_target.sv | 147 ++++++++++++++
 tb/tb_spi_ram_target.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_target_pkg.sv
// Shared SPI RAM protocol constants: opcodes, target FSM encoding and pin-edge pulses.
// The CPU-side SPI reader imports the same opcode constants.
package spi_ram_target_pkg;

   localparam logic [7:0] SPI_OP_READ  = 8'h03;
   localparam logic [7:0] SPI_OP_WRITE = 8'h02;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR_HI,
      ST_ADDR_LO,
      ST_RD_DATA,
      ST_WR_DATA,
      ST_IGNORE
   } spi_state_e;

   typedef struct packed {
      logic sck_rise;
      logic sck_fall;
      logic cs_fall;
      logic cs_rise;
   } spi_edges_t;

endpackage

// File: rtl/spi_pin_sync.sv
// 2-FF synchronizers for the SPI target pins plus one-cycle SCK/CS edge pulses.
module spi_pin_sync
   import spi_ram_target_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       cs_n,
   input  logic       sck,
   input  logic       mosi,
   output logic       mosi_s,
   output spi_edges_t edges
);

   // [1:0] synchronizer, [2] previous synchronized value for edge detection
   logic [2:0] cs_q;
   logic [2:0] sck_q;
   logic [1:0] mosi_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         // CS resets as "asserted": a CS still low after reset must first go high
         // before a new fall can start a transaction.
         cs_q   <= '0;
         sck_q  <= '0;
         mosi_q <= '0;
      end else begin
         cs_q   <= {cs_q[1:0], cs_n};
         sck_q  <= {sck_q[1:0], sck};
         mosi_q <= {mosi_q[0], mosi};
      end
   end

   assign mosi_s = mosi_q[1];

   always_comb begin
      edges.sck_rise = sck_q[1] & ~sck_q[2];
      edges.sck_fall = ~sck_q[1] & sck_q[2];
      edges.cs_fall  = ~cs_q[1] & cs_q[2];
      edges.cs_rise  = cs_q[1] & ~cs_q[2];
   end

endmodule

// File: rtl/spi_ram_target.sv
// SPI mode-0 RAM target: READ/WRITE with 16-bit address over a 2^ADDR_W byte memory,
// plus a local load port that is only open while no SPI transaction is active.
module spi_ram_target
   import spi_ram_target_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_cs_n,
   input  logic              spi_sck,
   input  logic              spi_mosi,
   output logic              spi_miso,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [7:0]        load_data,
   output logic              busy,
   output logic              cmd_err
);

   spi_edges_t  edges;
   logic        mosi_s;

   spi_state_e  state;
   logic [2:0]  bit_cnt;
   logic [7:0]  rx_sr;
   logic [7:0]  tx_sr;
   logic        miso_q;
   logic        cmd_err_q;
   logic        is_read;
   logic [7:0]  addr_hi;
   logic [15:0] addr;
   logic [1:0]  rd_pipe;
   logic [7:0]  rd_data;

   logic [7:0]  mem [2**ADDR_W];

   logic [7:0]  rx_next;
   logic        active;
   logic        byte_done;
   logic        rd_trig;
   logic        spi_we;
   logic        load_fire;

   spi_pin_sync u_sync (
      .clk    (clk),
      .rst    (rst),
      .cs_n   (spi_cs_n),
      .sck    (spi_sck),
      .mosi   (spi_mosi),
      .mosi_s (mosi_s),
      .edges  (edges)
   );

   assign rx_next   = {rx_sr[6:0], mosi_s};
   assign active    = (state != ST_IDLE) && (state != ST_IGNORE);
   assign byte_done = active && edges.sck_rise && (bit_cnt == 3'd7);
   // Read fetch: address settles, then the memory read, then the TX load
   assign rd_trig   = byte_done && (((state == ST_ADDR_LO) && is_read) || (state == ST_RD_DATA));
   assign spi_we    = byte_done && (state == ST_WR_DATA);
   assign load_fire = load_valid && load_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         rx_sr     <= '0;
         tx_sr     <= '0;
         miso_q    <= 1'b0;
         cmd_err_q <= 1'b0;
         is_read   <= 1'b0;
         addr_hi   <= '0;
         addr      <= '0;
         rd_pipe   <= '0;
      end else begin
         cmd_err_q <= 1'b0;
         rd_pipe   <= {rd_pipe[0], rd_trig};
         if (edges.cs_rise) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            rx_sr   <= '0;
            tx_sr   <= '0;
            miso_q  <= 1'b0;
            rd_pipe <= '0;
         end else if (state == ST_IDLE) begin
            if (edges.cs_fall) begin
               state   <= ST_CMD;
               bit_cnt <= '0;
               rx_sr   <= '0;
            end
         end else if (state != ST_IGNORE) begin
            if (edges.sck_rise) begin
               rx_sr   <= rx_next;
               bit_cnt <= bit_cnt + 3'd1;
            end
            if (edges.sck_fall) begin
               miso_q <= (state == ST_RD_DATA) ? tx_sr[7] : 1'b0;
               tx_sr  <= {tx_sr[6:0], 1'b0};
            end
            if (rd_pipe[1])
               tx_sr <= rd_data;
            if (byte_done) begin
               case (state)
                  ST_CMD: begin
                     if (rx_next == SPI_OP_READ) begin
                        is_read <= 1'b1;
                        state   <= ST_ADDR_HI;
                     end else if (rx_next == SPI_OP_WRITE) begin
                        is_read <= 1'b0;
                        state   <= ST_ADDR_HI;
                     end else begin
                        state     <= ST_IGNORE;
                        cmd_err_q <= 1'b1;
                     end
                  end
                  ST_ADDR_HI: begin
                     addr_hi <= rx_next;
                     state   <= ST_ADDR_LO;
                  end
                  ST_ADDR_LO: begin
                     addr  <= {addr_hi, rx_next};
                     state <= is_read ? ST_RD_DATA : ST_WR_DATA;
                  end
                  ST_RD_DATA, ST_WR_DATA: addr <= addr + 16'd1;
                  default: ;
               endcase
            end
         end
      end
   end

   // Single write port: SPI writes only happen while busy, loads only while idle
   always_ff @(posedge clk) begin
      if (spi_we)
         mem[addr[ADDR_W-1:0]] <= rx_next;
      else if (load_fire)
         mem[load_addr] <= load_data;
      rd_data <= mem[addr[ADDR_W-1:0]];
   end

   assign spi_miso   = miso_q;
   assign cmd_err    = cmd_err_q;
   assign busy       = (state != ST_IDLE);
   assign load_ready = ~busy;

endmodule

// File: tb/tb_spi_ram_target.sv
// Self-checking bench for spi_ram_target: table of SPI transactions, hand-written corner
// sequences, and random traffic checked against a flat byte-array memory model.
module tb_spi_ram_target;

   localparam int ADDR_W = 8;
   localparam int HALF   = 10;
   localparam logic [7:0] OP_RD = 8'h03;
   localparam logic [7:0] OP_WR = 8'h02;

   logic              clk = 1'b0;
   logic              rst;
   logic              spi_cs_n, spi_sck, spi_mosi, spi_miso;
   logic              load_valid, load_ready, busy, cmd_err;
   logic [ADDR_W-1:0] load_addr;
   logic [7:0]        load_data;

   int   checks = 0;
   int   errors = 0;
   logic [7:0] model [256];
   int   cmd_err_cnt = 0;
   int   miso_hi_cnt = 0;
   int   lr_viol = 0;
   bit   watch_miso = 1'b0;
   bit   in_window = 1'b0;

   always #5 clk = ~clk;

   spi_ram_target #(.ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .spi_cs_n   (spi_cs_n),
      .spi_sck    (spi_sck),
      .spi_mosi   (spi_mosi),
      .spi_miso   (spi_miso),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_addr  (load_addr),
      .load_data  (load_data),
      .busy       (busy),
      .cmd_err    (cmd_err)
   );

   always @(negedge clk) begin
      if (cmd_err) cmd_err_cnt++;
      if (watch_miso && spi_miso) miso_hi_cnt++;
      if (in_window && load_ready) lr_viol++;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct packed {
      logic [7:0]  op;
      logic [15:0] addr;
      logic [2:0]  n;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [5];

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic xfer(input logic [7:0] tx, input int nb, output logic [7:0] rx);
      rx = '0;
      for (int i = 0; i < nb; i++) begin
         spi_mosi = tx[7-i];
         wait_clk(HALF);
         rx = {rx[6:0], spi_miso};
         spi_sck = 1'b1;
         wait_clk(HALF);
         spi_sck = 1'b0;
      end
   endtask

   task automatic spi_txn(input logic [7:0] op, input logic [15:0] addr, input int n,
                          input logic [31:0] wdata, input int abort_bits,
                          output logic [31:0] rdata);
      logic [7:0] rx;
      rdata = '0;
      spi_cs_n = 1'b0;
      wait_clk(6);
      in_window = 1'b1;
      xfer(op, 8, rx);
      xfer(addr[15:8], 8, rx);
      xfer(addr[7:0], 8, rx);
      for (int i = 0; i < n; i++) begin
         xfer(wdata[31-8*i -: 8], 8, rx);
         rdata[31-8*i -: 8] = rx;
      end
      if (abort_bits > 0) xfer(8'hC3, abort_bits, rx);
      wait_clk(6);
      in_window = 1'b0;
      spi_cs_n = 1'b1;
      wait_clk(12);
   endtask

   task automatic load(input logic [7:0] a, input logic [7:0] d);
      load_valid = 1'b1;
      load_addr  = a;
      load_data  = d;
      @(negedge clk);
      load_valid = 1'b0;
      model[a]   = d;
   endtask

   task automatic model_write(input logic [15:0] a, input int n, input logic [31:0] d);
      logic [15:0] ai;
      for (int i = 0; i < n; i++) begin
         ai = a + 16'(i);
         model[ai[7:0]] = d[31-8*i -: 8];
      end
   endtask

   task automatic check_read(input string tag, input logic [15:0] a, input int n,
                             input logic [31:0] rd);
      logic [15:0] ai;
      for (int i = 0; i < n; i++) begin
         ai = a + 16'(i);
         check($sformatf("%s_b%0d", tag, i), {24'h0, rd[31-8*i -: 8]}, {24'h0, model[ai[7:0]]});
      end
   endtask

   initial begin
      logic [31:0] rd;
      logic [7:0]  rx;
      logic [7:0]  op;
      logic [15:0] a;
      logic [31:0] wd;
      int          n;
      int          e0;

      vecs[0] = '{op: OP_RD, addr: 16'h0000, n: 3'd3, wdata: 32'h0,         exp: 32'h1A258000};
      vecs[1] = '{op: OP_WR, addr: 16'h0010, n: 3'd2, wdata: 32'hAA550000, exp: 32'h0};
      vecs[2] = '{op: OP_RD, addr: 16'h0010, n: 3'd2, wdata: 32'h0,         exp: 32'hAA550000};
      vecs[3] = '{op: OP_WR, addr: 16'h12FF, n: 3'd2, wdata: 32'h11220000, exp: 32'h0};
      vecs[4] = '{op: OP_RD, addr: 16'h00FF, n: 3'd2, wdata: 32'h0,         exp: 32'h11220000};

      rst = 1'b1; spi_cs_n = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
      load_valid = 1'b0; load_addr = '0; load_data = '0;
      wait_clk(5);
      check("reset_miso",       {31'h0, spi_miso},   32'h0);
      check("reset_busy",       {31'h0, busy},       32'h0);
      check("reset_cmd_err",    {31'h0, cmd_err},    32'h0);
      check("reset_load_ready", {31'h0, load_ready}, 32'h1);
      rst = 1'b0;
      wait_clk(10);

      for (int i = 0; i < 256; i++) load(8'(i), 8'($urandom));
      load(8'h00, 8'h1A);
      load(8'h01, 8'h25);
      load(8'h02, 8'h80);

      for (int v = 0; v < 5; v++) begin
         spi_txn(vecs[v].op, vecs[v].addr, int'(vecs[v].n), vecs[v].wdata, 0, rd);
         if (vecs[v].op == OP_WR)
            model_write(vecs[v].addr, int'(vecs[v].n), vecs[v].wdata);
         else
            for (int i = 0; i < int'(vecs[v].n); i++)
               check($sformatf("vec%0d_b%0d", v, i), {24'h0, rd[31-8*i -: 8]},
                     {24'h0, vecs[v].exp[31-8*i -: 8]});
      end
      check("load_ready_low_in_cs", lr_viol, 0);

      // unsupported opcode followed by 16 bits
      e0 = cmd_err_cnt;
      watch_miso = 1'b1;
      spi_txn(8'h9F, 16'h0300, 0, 32'h0, 0, rd);
      watch_miso = 1'b0;
      check("bad_op_cmd_err_pulses", cmd_err_cnt - e0, 1);
      check("bad_op_miso_high",      miso_hi_cnt, 0);
      spi_txn(OP_RD, 16'h0000, 1, 32'h0, 0, rd);
      check("bad_op_mem0", {24'h0, rd[31:24]}, 32'h22);

      // CS raised 5 bits into a write data byte
      load(8'h20, 8'h5A);
      spi_txn(OP_WR, 16'h0020, 0, 32'h0, 5, rd);
      spi_txn(OP_RD, 16'h0020, 2, 32'h0, 0, rd);
      check("abort_mem20", {24'h0, rd[31:24]}, 32'h5A);
      check_read("abort_read", 16'h0020, 2, rd);

      // reset in the middle of a read data byte with CS held low
      spi_cs_n = 1'b0;
      wait_clk(6);
      xfer(OP_RD, 8, rx);
      xfer(8'h00, 8, rx);
      xfer(8'h00, 8, rx);
      xfer(8'h00, 3, rx);
      rst = 1'b1;
      wait_clk(2);
      rst = 1'b0;
      wait_clk(2);
      check("rst_mid_miso", {31'h0, spi_miso}, 32'h0);
      check("rst_mid_busy", {31'h0, busy},     32'h0);
      xfer(OP_RD, 8, rx);
      xfer(8'h00, 8, rx);
      xfer(8'h00, 8, rx);
      xfer(8'h00, 8, rx);
      check("rst_cs_low_miso", {24'h0, rx}, 32'h0);
      check("rst_cs_low_busy", {31'h0, busy}, 32'h0);
      wait_clk(6);
      spi_cs_n = 1'b1;
      wait_clk(12);
      spi_txn(OP_RD, 16'h0001, 2, 32'h0, 0, rd);
      check_read("rst_after_read", 16'h0001, 2, rd);

      for (int t = 0; t < 15; t++) begin
         op = ($urandom_range(0, 1) == 1) ? OP_RD : OP_WR;
         a  = 16'($urandom);
         n  = int'($urandom_range(1, 4));
         wd = $urandom;
         if ($urandom_range(0, 3) == 0) load(8'($urandom), 8'($urandom));
         spi_txn(op, a, n, wd, 0, rd);
         if (op == OP_WR) model_write(a, n, wd);
         else check_read($sformatf("rand%0d", t), a, n, rd);
      end
      // read back a random-write region to catch write-path faults
      spi_txn(OP_RD, a, 4, 32'h0, 0, rd);
      check_read("rand_final", a, 4, rd);
      check("load_ready_low_total", lr_viol, 0);
      check("cmd_err_total", cmd_err_cnt, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
